// File: rtl/dac_sample_fifo_pkg.sv
// dac_sample_fifo_pkg: DAC sample type and range constants shared by paths into the PWM DAC
package dac_sample_fifo_pkg;
    localparam int DAC_WIDTH = 8;
    typedef logic signed [DAC_WIDTH-1:0] dac_sample_t;
    localparam dac_sample_t DAC_MAX = 8'sh7F;
    localparam dac_sample_t DAC_MIN = 8'sh80;
    localparam dac_sample_t DAC_MID = 8'sh00;
endpackage

// File: rtl/dac_sample_fifo_sat_shift.sv
// sat_shift: arithmetic right shift of a wide signed sample, saturated to the DAC range
module sat_shift
    import dac_sample_fifo_pkg::*;
#(
    parameter int IN_WIDTH = 16,
    parameter int SHIFT    = 8
) (
    input  logic signed [IN_WIDTH-1:0] din,
    output dac_sample_t                dout
);
    localparam logic signed [IN_WIDTH-1:0] HI = {{(IN_WIDTH-DAC_WIDTH){DAC_MAX[DAC_WIDTH-1]}}, DAC_MAX};
    localparam logic signed [IN_WIDTH-1:0] LO = {{(IN_WIDTH-DAC_WIDTH){DAC_MIN[DAC_WIDTH-1]}}, DAC_MIN};
    logic signed [IN_WIDTH-1:0] s;
    assign s    = din >>> SHIFT;
    assign dout = s > HI ? DAC_MAX : s < LO ? DAC_MIN : s[DAC_WIDTH-1:0];
endmodule

// File: rtl/dac_sample_fifo.sv
// dac_sample_fifo: scaled sample FIFO feeding the PWM DAC; define SAMPLE_FIFO_UNDERRUN_HOLD_EN to hold dout on underrun
module dac_sample_fifo
    import dac_sample_fifo_pkg::*;
#(
    parameter int DEPTH    = 16,
    parameter int IN_WIDTH = 16,
    parameter int SHIFT    = 8
) (
    input  logic                      clk,
    input  logic                      rst_an,
    input  logic signed [IN_WIDTH-1:0] din,
    input  logic                      din_valid,
    output logic                      din_ready,
    output dac_sample_t               dout,
    input  logic                      dout_ack,
    output logic [$clog2(DEPTH):0]    level,
    output logic [7:0]                underrun_cnt,
    input  logic                      underrun_clr
);
    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL = (AW+1)'(DEPTH);
    dac_sample_t       mem [DEPTH];
    dac_sample_t       conv;
    logic [AW-1:0]     wptr, rptr;
    logic              push, pop, under;
    sat_shift #(.IN_WIDTH(IN_WIDTH), .SHIFT(SHIFT)) u_sat (.din(din), .dout(conv));
    assign din_ready = level != FULL;
    assign push      = din_valid && din_ready;
    assign pop       = dout_ack && level != '0;
    assign under     = dout_ack && level == '0;
    // sample storage; contents need no reset since level gates every read
    always_ff @(posedge clk) begin
        if (push) mem[wptr] <= conv;
    end
    // pointers, occupancy and the registered head sample
    always_ff @(posedge clk or negedge rst_an) begin
        if (!rst_an) begin
            wptr  <= '0;
            rptr  <= '0;
            level <= '0;
            dout  <= DAC_MID;
        end else begin
            wptr  <= push ? wptr + AW'(1) : wptr;
            rptr  <= pop ? rptr + AW'(1) : rptr;
            level <= level + (AW+1)'(push) - (AW+1)'(pop);
            if (pop) dout <= mem[rptr];
`ifdef SAMPLE_FIFO_UNDERRUN_HOLD_EN
`else
            else if (under) dout <= DAC_MID;
`endif
        end
    end
    // saturating underrun counter; clear beats increment
    always_ff @(posedge clk or negedge rst_an) begin
        if (!rst_an) underrun_cnt <= '0;
        else if (underrun_clr) underrun_cnt <= '0;
        else if (under && underrun_cnt != 8'hFF) underrun_cnt <= underrun_cnt + 8'd1;
    end
endmodule

// File: tb/tb_dac_sample_fifo.sv
// tb_dac_sample_fifo: directed and random stimulus against a queue-based reference model
module tb_dac_sample_fifo;
    localparam int DEPTH    = 16;
    localparam int IN_WIDTH = 16;
    localparam int SHIFT    = 8;
    logic                       clk = 1'b0;
    logic                       rst_an;
    logic signed [IN_WIDTH-1:0] din;
    logic                       din_valid, din_ready, dout_ack, underrun_clr;
    logic signed [7:0]          dout;
    logic [$clog2(DEPTH):0]     level;
    logic [7:0]                 underrun_cnt;
    int vectors = 0, errors = 0;
    int q[$];
    int m_dout = 0, m_cnt = 0;
    dac_sample_fifo #(.DEPTH(DEPTH), .IN_WIDTH(IN_WIDTH), .SHIFT(SHIFT)) dut (
        .clk(clk), .rst_an(rst_an), .din(din), .din_valid(din_valid), .din_ready(din_ready),
        .dout(dout), .dout_ack(dout_ack), .level(level), .underrun_cnt(underrun_cnt),
        .underrun_clr(underrun_clr)
    );
    always #5 clk = ~clk;
    task automatic check(input string tag, input int got, input int exp);
        vectors++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
        end
    endtask
    function automatic int conv(input logic [IN_WIDTH-1:0] x);
        int s;
        s = int'($signed(x)) >>> SHIFT;
        return s > 127 ? 127 : s < -128 ? -128 : s;
    endfunction
    task automatic check_outputs();
        check("dout", int'(dout), m_dout);
        check("level", int'(level), q.size());
        check("underrun_cnt", int'(underrun_cnt), m_cnt);
    endtask
    task automatic step(input logic v, input logic [IN_WIDTH-1:0] d, input logic a, input logic c);
        bit ready, under;
        din_valid = v; din = d; dout_ack = a; underrun_clr = c;
        ready = q.size() != DEPTH;
        check("din_ready", int'(din_ready), int'(ready));
        under = a && q.size() == 0;
        if (a && !under) m_dout = q.pop_front();
`ifndef SAMPLE_FIFO_UNDERRUN_HOLD_EN
        else if (under) m_dout = 0;
`endif
        if (v && ready) q.push_back(conv(d));
        m_cnt = c ? 0 : (under && m_cnt < 255) ? m_cnt + 1 : m_cnt;
        @(posedge clk);
        #1;
        check_outputs();
    endtask
    task automatic async_reset();
        rst_an = 1'b0;
        q.delete(); m_dout = 0; m_cnt = 0;
        #1;
        check_outputs();
        check("din_ready_rst", int'(din_ready), 1);
        @(posedge clk);
        #1 rst_an = 1'b1;
    endtask
    initial begin
        logic [IN_WIDTH-1:0] pat [4];
        int exp_seq [4];
        pat = '{16'h1234, 16'h7FFF, 16'h8000, 16'hFF00};
        exp_seq = '{18, 127, -128, -1};
        rst_an = 1'b1; din = '0; din_valid = 0; dout_ack = 0; underrun_clr = 0;
        #2 async_reset();
        for (int i = 0; i < 3; i++) step(0, 0, 1, 0);
        check("underrun_3", int'(underrun_cnt), 3);
        for (int i = 0; i < 4; i++) step(1, pat[i], 0, 0);
        for (int i = 0; i < 4; i++) begin
            step(0, 0, 1, 0);
            check("conv_seq", int'(dout), exp_seq[i]);
        end
        for (int i = 0; i < DEPTH + 1; i++) step(1, IN_WIDTH'(i << SHIFT), 0, 0);
        check("full_level", int'(level), DEPTH);
        check("full_ready", int'(din_ready), 0);
        step(1, 16'h0100, 1, 0);
        check("full_pop_ready", int'(din_ready), 1);
        for (int i = 1; i < DEPTH; i++) begin
            step(0, 0, 1, 0);
            check("fill_order", int'(dout), i);
        end
        check("drained", int'(level), 0);
        step(1, 16'h2200, 1, 0);
        check("empty_push_level", int'(level), 1);
        step(1, 16'h4000, 1, 0);
        check("bypass_none", int'(dout), 'h22);
        step(0, 0, 1, 0);
        check("head_40", int'(dout), 'h40);
        step(0, 0, 1, 1);
`ifdef SAMPLE_FIFO_UNDERRUN_HOLD_EN
        check("underrun_hold", int'(dout), 'h40);
`else
        check("underrun_zero", int'(dout), 0);
`endif
        check("clr_wins", int'(underrun_cnt), 0);
        for (int i = 0; i < 300; i++) step(0, 0, 1, 0);
        check("cnt_saturate", int'(underrun_cnt), 255);
        for (int i = 0; i < 3000; i++) begin
            if (i == 1500) async_reset();
            step(1'($urandom_range(0, 99) < 55), IN_WIDTH'($urandom),
                 1'($urandom_range(0, 99) < 45), 1'($urandom_range(0, 99) < 2));
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end
endmodule
